// File: rtl/if_fetch_stage_pkg.sv
// Core-wide fetch definitions: data width, the canonical NOP, the default
// boot PC and the FIFO entry layout.
package if_fetch_stage_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Instructions are word aligned; low address bits are simply dropped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} pairs. Head is read
// straight from the storage registers, so a push becomes visible one cycle
// later (no bypass). Flush empties the queue in one cycle.
module if_fifo
  import if_fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  input  logic                         flush,
  output fetch_entry_t                 head,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  rd_ptr_q;
  logic [AW-1:0]  wr_ptr_q;
  logic [CW-1:0]  count_q;
  logic           do_push;
  logic           do_pop;

  // Guard against pops when empty and pushes when full with no pop.
  always_comb begin
    do_pop  = pop && (count_q != '0);
    do_push = push && ((count_q != CW'(DEPTH)) || do_pop);
  end

  // Pointer and occupancy tracking; flush wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents are only observed while non-empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: issues word-aligned fetches under a credit limit,
// buffers in-order responses with their PCs and hands them to decode.
// Redirects restart fetch and discard everything already in flight.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            id_ready,
  output logic            if_valid,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4_out,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = CW + 2;

  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] resp_pc_q;
  logic [XLEN-1:0] pc_hold_q;
  logic [CW-1:0]   outstanding_q;
  logic [CW-1:0]   outstanding_nxt;
  logic [CW-1:0]   drop_cnt_q;
  logic [CW-1:0]   fifo_count;
  logic [SW-1:0]   committed;
  logic            fire;
  logic            push;
  logic            pop;
  logic            fifo_empty;
  fetch_entry_t    head;

  // Every slot that is requested, buffered or awaiting discard holds a credit,
  // so the buffer can always absorb every response that is kept.
  always_comb begin
    committed       = SW'(outstanding_q) + SW'(fifo_count) + SW'(drop_cnt_q);
    imem_req        = rst_n && !redirect_valid && (committed < SW'(FIFO_DEPTH));
    fire            = imem_req && imem_gnt;
    push            = imem_rvalid && (drop_cnt_q == '0) && !redirect_valid;
    outstanding_nxt = outstanding_q + CW'(fire) - CW'(imem_rvalid);
  end

  assign imem_addr = fetch_pc_q;

  if_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ('{pc: resp_pc_q, instr: imem_rdata}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign if_valid     = !fifo_empty;
  assign pop          = if_valid && id_ready;
  assign instr_out    = if_valid ? head.instr : NOP_INSTR;
  assign pc_out       = if_valid ? head.pc : pc_hold_q;
  assign pc_plus4_out = pc_out + 32'd4;

  // PC generation, credit and drop bookkeeping; a redirect turns everything
  // still in flight after this cycle into responses to be discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      pc_hold_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      outstanding_q <= outstanding_nxt;
      if (if_valid) pc_hold_q <= head.pc;
      if (redirect_valid) begin
        fetch_pc_q <= word_align(redirect_pc);
        resp_pc_q  <= word_align(redirect_pc);
        drop_cnt_q <= outstanding_nxt;
      end else begin
        if (fire) fetch_pc_q <= fetch_pc_q + 32'd4;
        if (push) resp_pc_q  <= resp_pc_q + 32'd4;
        if (imem_rvalid && (drop_cnt_q != '0)) drop_cnt_q <= drop_cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: an in-order memory responder plus a
// transaction-level model of the expected fetch and delivery PC streams.
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        id_ready = 1'b0;
  logic        if_valid;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4_out;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  if_fetch_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_ready(id_ready), .if_valid(if_valid), .instr_out(instr_out),
    .pc_out(pc_out), .pc_plus4_out(pc_plus4_out),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] target; int lat; int need_out; logic [31:0] exp_pc; } redir_vec_t;

  mreq_t       mq[$];
  redir_vec_t  vecs[4];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_due = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          n_del = 0;
  int          first_req_cyc = -1;
  int          first_val_cyc = -1;
  logic [31:0] exp_fetch = RESET_PC;
  logic [31:0] exp_del = RESET_PC;
  logic [31:0] last_pc = RESET_PC;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'hA5A5_5A5A;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: starts in the low phase with inputs set, samples outputs,
  // updates the memory and reference model, ends at the next negedge.
  task automatic tick();
    int lat;
    logic rsp;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mq[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
    #1;
    rsp = imem_rvalid;
    if (redirect_valid) check32("req_in_redirect", 32'(imem_req), 32'd0);
    if (imem_req) check32("fetch_addr", imem_addr, exp_fetch);
    if (!if_valid) begin
      check32("empty_instr_nop", instr_out, NOP);
      check32("empty_pc_hold", pc_out, last_pc);
    end
    check32("pc_plus4", pc_plus4_out, pc_out + 32'd4);
    check32("credit_bound", 32'(mq.size() <= DEPTH), 32'd1);
    if (imem_req && first_req_cyc < 0) first_req_cyc = cyc;
    if (if_valid && first_val_cyc < 0) first_val_cyc = cyc;
    if (if_valid && id_ready && !redirect_valid) begin
      check32("deliver_pc", pc_out, exp_del);
      check32("deliver_instr", instr_out, mem_word(exp_del));
      exp_del = exp_del + 32'd4;
      n_del++;
    end
    if (if_valid) last_pc = pc_out;
    if (imem_req && imem_gnt) begin
      lat = $urandom_range(lat_max, lat_min);
      if (mq.size() > 0 && cyc + lat <= last_due) last_due = last_due + 1;
      else last_due = cyc + lat;
      mq.push_back('{addr: imem_addr, due: last_due});
      exp_fetch = exp_fetch + 32'd4;
    end
    if (rsp) void'(mq.pop_front());
    if (redirect_valid) begin
      exp_fetch = {redirect_pc[31:2], 2'b00};
      exp_del   = {redirect_pc[31:2], 2'b00};
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_valid(input int max_cyc, input string name);
    int n = 0;
    while (!if_valid && n < max_cyc) begin
      tick();
      n++;
    end
    checks++;
    if (!if_valid) begin
      errors++;
      $display("FAIL %s timeout actual=if_valid 0 expected=if_valid 1 within %0d cycles", name, max_cyc);
    end
  endtask

  // Async assert: outputs must show reset values without any clock edge.
  task automatic do_reset();
    rst_n       = 1'b0;
    imem_rvalid = 1'b0;
    mq.delete();
    last_due  = 0;
    exp_fetch = RESET_PC;
    exp_del   = RESET_PC;
    last_pc   = RESET_PC;
    #1;
    check32("rst_if_valid", 32'(if_valid), 32'd0);
    check32("rst_imem_req", 32'(imem_req), 32'd0);
    check32("rst_instr_nop", instr_out, NOP);
    check32("rst_pc_out", pc_out, RESET_PC);
    check32("rst_pc_plus4", pc_plus4_out, RESET_PC + 32'd4);
  endtask

  initial begin
    logic [31:0] pc0;
    logic [31:0] a0;
    int n0;
    int guard;

    vecs[0] = '{target: 32'h0000_0100, lat: 3, need_out: 2, exp_pc: 32'h0000_0100};
    vecs[1] = '{target: 32'h0000_0203, lat: 1, need_out: 1, exp_pc: 32'h0000_0200};
    vecs[2] = '{target: 32'hFFFF_FFFD, lat: 2, need_out: 2, exp_pc: 32'hFFFF_FFFC};
    vecs[3] = '{target: 32'h0000_0042, lat: 2, need_out: 1, exp_pc: 32'h0000_0040};

    #2;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming at 1-cycle latency, decode always ready
    imem_gnt = 1'b1;
    id_ready = 1'b1;
    lat_min  = 1;
    lat_max  = 1;
    repeat (12) tick();
    check32("req_to_valid_latency", 32'(first_val_cyc - first_req_cyc), 32'd2);

    // Decode backpressure: head holds still
    id_ready = 1'b0;
    wait_valid(10, "bp_valid");
    pc0 = pc_out;
    repeat (6) begin
      tick();
      check32("bp_valid_hold", 32'(if_valid), 32'd1);
      check32("bp_pc_hold", pc_out, pc0);
    end
    id_ready = 1'b1;
    repeat (8) tick();

    // Grant withheld: address stable, no advance
    imem_gnt = 1'b0;
    repeat (4) tick();
    check32("nognt_req", 32'(imem_req), 32'd1);
    a0 = imem_addr;
    repeat (4) begin
      tick();
      check32("nognt_addr_stable", imem_addr, a0);
    end
    imem_gnt = 1'b1;
    repeat (8) tick();

    // Redirect table
    foreach (vecs[i]) begin
      lat_min = vecs[i].lat;
      lat_max = vecs[i].lat;
      guard = 0;
      while (mq.size() < vecs[i].need_out && guard < 20) begin
        tick();
        guard++;
      end
      check32("redir_outstanding", 32'(mq.size() >= vecs[i].need_out), 32'd1);
      redirect_valid = 1'b1;
      redirect_pc    = vecs[i].target;
      tick();
      redirect_valid = 1'b0;
      check32("redir_flush_valid", 32'(if_valid), 32'd0);
      wait_valid(20, "redir_valid");
      check32("redir_first_pc", pc_out, vecs[i].exp_pc);
      check32("redir_first_instr", instr_out, mem_word(vecs[i].exp_pc));
      repeat (10) tick();
    end

    // Randomized traffic with random redirects
    lat_min = 1;
    lat_max = 4;
    repeat (800) begin
      imem_gnt       = ($urandom_range(3, 0) != 0);
      id_ready       = ($urandom_range(2, 0) != 0);
      redirect_valid = ($urandom_range(39, 0) == 0);
      redirect_pc    = $urandom;
      tick();
    end
    redirect_valid = 1'b0;

    // Liveness after random traffic
    imem_gnt = 1'b1;
    id_ready = 1'b1;
    lat_min  = 1;
    lat_max  = 1;
    n0 = n_del;
    repeat (30) tick();
    check32("liveness", 32'(n_del - n0 >= 8), 32'd1);

    // Reset mid-stream with the buffer full
    id_ready = 1'b0;
    repeat (8) tick();
    check32("full_before_reset", 32'(if_valid), 32'd1);
    #2;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check32("restart_req", 32'(imem_req), 32'd1);
    check32("restart_addr", imem_addr, RESET_PC);
    id_ready = 1'b1;
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
